// File: rtl/core_pkg.sv
// Shared types and instruction-field positions for the 2-stage pipelined core.
package core_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SLL  = 4'h6,
        OP_LI   = 4'h7,
        OP_BEQZ = 4'h8,
        OP_JMP  = 4'h9,
        OP_RSVA = 4'hA,
        OP_RSVB = 4'hB,
        OP_RSVC = 4'hC,
        OP_RSVD = 4'hD,
        OP_RSVE = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int INSTR_W = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int IMM_W   = 8;

endpackage

// File: rtl/core_alu.sv
// Combinational ALU covering the register-register opcodes ADD..SLL.
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << b[3:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_core.sv
// Two-stage core: fetch register feeding an execute+writeback stage, with run
// handshake, sticky illegal flag, saturating retire counter and debug read port.
module pipelined_core
    import core_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int NREGS      = 4,
    parameter  int IMEM_DEPTH = 16,
    parameter  int CNT_W      = 16,
    localparam int PC_W       = $clog2(IMEM_DEPTH),
    localparam int RI_W       = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retire_count,
    input  logic [RI_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam logic [3:0] FIELD_MASK = 4'((1 << RI_W) - 1);

    state_e               state, state_next;
    logic [PC_W-1:0]      pc, pc_inc, tgt;
    logic [PC_W:0]        tgt_ext;
    logic [INSTR_W-1:0]   if_instr;
    logic                 if_valid;
    logic [DATA_W-1:0]    regs [NREGS];

    opcode_e              op;
    logic [RI_W-1:0]      rd_i, rs1_i, rs2_i;
    logic [DATA_W-1:0]    rd_val, a_val, b_val, alu_y, wr_data;
    logic                 exe, accept, wr_en, take, halt_ex, illegal_ex;

    // Field index bits above RI_W are dropped; unused slots of a non-power-of-2 file read as 0.
    function automatic logic [RI_W-1:0] idx_of(input logic [3:0] field);
        return RI_W'(field & FIELD_MASK);
    endfunction

    function automatic logic reg_ok(input logic [RI_W-1:0] i);
        return 32'(i) < NREGS;
    endfunction

    assign op     = opcode_e'(if_instr[OP_MSB:OP_LSB]);
    assign rd_i   = idx_of(if_instr[RD_LSB +: 4]);
    assign rs1_i  = idx_of(if_instr[RS1_LSB +: 4]);
    assign rs2_i  = idx_of(if_instr[RS2_LSB +: 4]);
    assign rd_val = reg_ok(rd_i)  ? regs[rd_i]  : '0;
    assign a_val  = reg_ok(rs1_i) ? regs[rs1_i] : '0;
    assign b_val  = reg_ok(rs2_i) ? regs[rs2_i] : '0;

    assign dbg_data  = reg_ok(dbg_addr) ? regs[dbg_addr] : '0;
    assign imem_addr = pc;
    assign busy      = (state == RUN);
    assign halted    = (state == HALT);
    assign exe       = (state == RUN) && if_valid;

    // Wrap for non-power-of-2 depths: the raw target is below 2*IMEM_DEPTH, so one subtract suffices.
    assign pc_inc  = (pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc + PC_W'(1);
    assign tgt_ext = {1'b0, if_instr[PC_W-1:0]};
    assign tgt     = (tgt_ext >= (PC_W+1)'(IMEM_DEPTH))
                     ? PC_W'(tgt_ext - (PC_W+1)'(IMEM_DEPTH)) : if_instr[PC_W-1:0];

    core_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op),
        .a  (a_val),
        .b  (b_val),
        .y  (alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        take       = 1'b0;
        halt_ex    = 1'b0;
        illegal_ex = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (exe) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL: begin
                            wr_en   = 1'b1;
                            wr_data = alu_y;
                        end
                        OP_LI: begin
                            wr_en   = 1'b1;
                            wr_data = DATA_W'($signed(if_instr[IMM_W-1:0]));
                        end
                        OP_BEQZ: take = (rd_val == '0);
                        OP_JMP:  take = 1'b1;
                        OP_HALT: begin
                            halt_ex    = 1'b1;
                            state_next = HALT;
                        end
                        OP_RSVA, OP_RSVB, OP_RSVC, OP_RSVD, OP_RSVE: illegal_ex = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= '0;
            if_instr     <= '0;
            if_valid     <= 1'b0;
            illegal      <= 1'b0;
            retire_count <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (accept) begin
            pc           <= '0;
            if_valid     <= 1'b0;
            illegal      <= 1'b0;
            retire_count <= '0;
        end else if (state == RUN) begin
            if (exe) begin
                if (retire_count != '1) retire_count <= retire_count + CNT_W'(1);
                if (illegal_ex) illegal <= 1'b1;
                if (wr_en && reg_ok(rd_i)) regs[rd_i] <= wr_data;
            end
            // HALT freezes PC; a taken branch squashes the word fetched behind it.
            if (halt_ex) begin
                if_valid <= 1'b0;
            end else if (take) begin
                pc       <= tgt;
                if_valid <= 1'b0;
            end else begin
                if_instr <= imem_data;
                if_valid <= 1'b1;
                pc       <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_core.sv
// Self-checking bench for pipelined_core: directed programs plus random
// forward-branching programs against an instruction-level reference model.
module tb_pipelined_core;

    localparam int DATA_W     = 16;
    localparam int NREGS      = 4;
    localparam int IMEM_DEPTH = 16;
    localparam int CNT_W      = 16;
    localparam int PC_W       = 4;
    localparam int RI_W       = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;
    logic              busy, halted, illegal;
    logic [CNT_W-1:0]  retire_count;
    logic [RI_W-1:0]   dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    logic [15:0] imem [IMEM_DEPTH];
    assign imem_data = imem[imem_addr];

    always #5 clk = ~clk;

    pipelined_core #(
        .DATA_W     (DATA_W),
        .NREGS      (NREGS),
        .IMEM_DEPTH (IMEM_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .busy         (busy),
        .halted       (halted),
        .illegal      (illegal),
        .retire_count (retire_count),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_regs [NREGS];
    int          m_retire, m_edges;
    logic        m_illegal;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ISA-level interpreter: executes the program in imem from address 0 until HALT.
    // Cycle cost: one fill cycle, one per executed word, one bubble per taken branch.
    task automatic model_run();
        int pc, nxt, op, rd, rs1, rs2;
        logic [15:0] w, a, b;
        pc = 0; m_retire = 0; m_illegal = 1'b0; m_edges = 1;
        for (int step = 0; step < 1000; step++) begin
            w   = imem[pc];
            op  = int'(w[15:12]);
            rd  = int'(w[11:8]) % NREGS;
            rs1 = int'(w[7:4]) % NREGS;
            rs2 = int'(w[3:0]) % NREGS;
            a   = m_regs[rs1];
            b   = m_regs[rs2];
            m_retire++;
            m_edges++;
            nxt = (pc + 1) % IMEM_DEPTH;
            case (op)
                1: m_regs[rd] = a + b;
                2: m_regs[rd] = a - b;
                3: m_regs[rd] = a & b;
                4: m_regs[rd] = a | b;
                5: m_regs[rd] = a ^ b;
                6: m_regs[rd] = a << b[3:0];
                7: m_regs[rd] = w[7] ? {8'hFF, w[7:0]} : {8'h00, w[7:0]};
                8: if (m_regs[rd] == 16'h0) begin nxt = int'(w[7:0]) % IMEM_DEPTH; m_edges++; end
                9: begin nxt = int'(w[7:0]) % IMEM_DEPTH; m_edges++; end
                10, 11, 12, 13, 14: m_illegal = 1'b1;
                15: break;
                default: ;
            endcase
            pc = nxt;
        end
        if (m_retire > (1 << CNT_W) - 1) m_retire = (1 << CNT_W) - 1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < NREGS; r++) m_regs[r] = 16'h0;
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < NREGS; r++) begin
            dbg_addr = RI_W'(r);
            #1;
            check($sformatf("%s_R%0d", tag, r), 32'(dbg_data), 32'(m_regs[r]));
        end
    endtask

    // Pulses start, counts edges until halted, then compares against the model.
    task automatic run_prog(input string tag, input int restart_at, output int edges);
        model_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        edges = 0;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_cnt_cleared"}, 32'(retire_count), 32'd0);
        check({tag, "_illegal_cleared"}, 32'(illegal), 32'd0);
        while (!halted && edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = (edges == restart_at);
        end
        start = 1'b0;
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_latency"}, 32'(edges), 32'(m_edges));
        check({tag, "_retire"}, 32'(retire_count), 32'(m_retire));
        check({tag, "_illegal"}, 32'(illegal), 32'(m_illegal));
        check_regs(tag);
    endtask

    initial begin
        int edges;
        logic [PC_W-1:0] held_addr;
        logic [3:0] f_op, f_rd, f_rs1, f_rs2;
        int k, t;

        dbg_addr = '0;
        clear_imem();
        do_reset();

        // 1: reset state, idle
        repeat (10) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_retire", 32'(retire_count), 32'd0);
        check("rst_pc", 32'(imem_addr), 32'd0);
        check_regs("rst");

        // 2: straight-line add
        clear_imem();
        imem[0] = 16'h7105; imem[1] = 16'h7203; imem[2] = 16'h1312; imem[3] = 16'hF000;
        run_prog("add", -1, edges);
        check("add_edges5", 32'(edges), 32'd5);
        dbg_addr = 2'd3; #1;
        check("add_r3_is_8", 32'(dbg_data), 32'h8);
        check("add_retire4", 32'(retire_count), 32'd4);
        held_addr = imem_addr;
        repeat (3) @(negedge clk);
        check("halt_pc_frozen", 32'(imem_addr), 32'(held_addr));
        check("halt_stays", 32'(halted), 32'd1);

        // 3: taken BEQZ flushes the wrong-path LI
        do_reset();
        clear_imem();
        imem[0] = 16'h7100; imem[1] = 16'h8104; imem[2] = 16'h7207; imem[3] = 16'h0000; imem[4] = 16'hF000;
        run_prog("beqz", -1, edges);
        dbg_addr = 2'd2; #1;
        check("beqz_r2_flushed", 32'(dbg_data), 32'h0);
        check("beqz_retire3", 32'(retire_count), 32'd3);

        // 4: sign-extended LI, SUB wrap, SLL by 15
        do_reset();
        clear_imem();
        imem[0] = 16'h71FF; imem[1] = 16'h2201; imem[2] = 16'h6321; imem[3] = 16'hF000;
        run_prog("sub_sll", -1, edges);
        dbg_addr = 2'd1; #1; check("li_sext", 32'(dbg_data), 32'hFFFF);
        dbg_addr = 2'd2; #1; check("sub_wrap", 32'(dbg_data), 32'h0001);
        dbg_addr = 2'd3; #1; check("sll_15", 32'(dbg_data), 32'h8000);

        // 5: reserved opcode sets sticky illegal; restart clears it
        clear_imem();
        imem[0] = 16'hB123; imem[1] = 16'hF000;
        run_prog("illegal", -1, edges);
        check("illegal_set", 32'(illegal), 32'd1);
        check("illegal_retire2", 32'(retire_count), 32'd2);
        imem[0] = 16'h0000;
        run_prog("illegal_restart", -1, edges);
        check("illegal_cleared", 32'(illegal), 32'd0);

        // random forward-branching programs; register state carries across runs
        for (int p = 0; p < 8; p++) begin
            for (int a = 0; a < IMEM_DEPTH - 1; a++) begin
                k     = $urandom_range(0, 9);
                f_rd  = 4'($urandom_range(0, 15));
                f_rs1 = 4'($urandom_range(0, 15));
                f_rs2 = 4'($urandom_range(0, 15));
                t     = $urandom_range(a + 1, IMEM_DEPTH - 1);
                case (k)
                    0, 1, 2, 9: f_op = 4'($urandom_range(1, 6));
                    3, 4:       f_op = 4'h7;
                    5:          f_op = 4'h8;
                    6:          f_op = 4'h9;
                    7:          f_op = 4'h0;
                    default:    f_op = 4'($urandom_range(10, 14));
                endcase
                if (f_op == 4'h8 || f_op == 4'h9) begin
                    f_rs1 = 4'($urandom_range(0, 15));
                    f_rs2 = 4'(t);
                end
                imem[a] = {f_op, f_rd, f_rs1, f_rs2};
            end
            imem[IMEM_DEPTH-1] = {4'hF, 12'($urandom_range(0, 4095))};
            run_prog($sformatf("rand%0d", p), -1, edges);
        end

        // 6: start during RUN is ignored; async reset aborts mid-run
        do_reset();
        clear_imem();
        imem[0] = 16'h7105; imem[1] = 16'h7203;
        imem[IMEM_DEPTH-1] = 16'hF000;
        run_prog("start_ignored", 5, edges);
        check("start_ignored_edges", 32'(edges), 32'(IMEM_DEPTH + 1));

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_pc", 32'(imem_addr), 32'd0);
        check("arst_retire", 32'(retire_count), 32'd0);
        for (int r = 0; r < NREGS; r++) m_regs[r] = 16'h0;
        check_regs("arst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_stays_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
